// File: rtl/writeback_stage_reg.sv
// writeback_stage_reg
//
// MEM/WB pipeline register plus the writeback datapath of the 5-stage
// RISC-V pipeline. It captures the memory-stage instruction (with stall and
// flush control), then selects the result written back to the register file:
// the ALU result, an aligned and sign/zero-extended load value, PC+4, or the
// extended immediate. It also counts retired instructions.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-low reset
//   stallW       hold the WB register contents
//   flushW       replace the incoming instruction with a bubble
//   validM       memory-stage instruction valid
//   RegWriteM    memory-stage instruction writes rd
//   ResultSrcM   result select: 00 ALU, 01 load, 10 PC+4, 11 immediate
//   funct3M      load size/sign encoding
//   ALUresultM   ALU result / load address
//   ReadDataM    raw aligned memory word
//   PCplus4M     link value
//   ImmExtM      extended immediate
//   RdM          destination register
//   ResultW      value written to the register file
//   RdW          destination register of the WB instruction
//   RegWriteW    effective register-file write enable (never for x0)
//   validW       WB stage holds a real instruction
//   retire_count retired-instruction count, wraps modulo 2^CNTW

module writeback_stage_reg #(
    parameter int XLEN  = 32,
    parameter int RADDR = 5,
    parameter int CNTW  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stallW,
    input  logic             flushW,
    input  logic             validM,
    input  logic             RegWriteM,
    input  logic [1:0]       ResultSrcM,
    input  logic [2:0]       funct3M,
    input  logic [XLEN-1:0]  ALUresultM,
    input  logic [XLEN-1:0]  ReadDataM,
    input  logic [XLEN-1:0]  PCplus4M,
    input  logic [XLEN-1:0]  ImmExtM,
    input  logic [RADDR-1:0] RdM,
    output logic [XLEN-1:0]  ResultW,
    output logic [RADDR-1:0] RdW,
    output logic             RegWriteW,
    output logic             validW,
    output logic [CNTW-1:0]  retire_count
);

    // Registered copies of the memory-stage fields.
    logic             reg_write_w;
    logic [1:0]       result_src_w;
    logic [2:0]       funct3_w;
    logic [XLEN-1:0]  alu_result_w;
    logic [XLEN-1:0]  read_data_w;
    logic [XLEN-1:0]  pc_plus4_w;
    logic [XLEN-1:0]  imm_ext_w;

    // Load alignment intermediates.
    logic [1:0]       offset_w;
    logic [7:0]       load_byte;
    logic [15:0]      load_half;
    logic [XLEN-1:0]  load_ext;

    // Asserted on edges where the WB register actually takes a new instruction.
    logic             load_en;

    assign load_en = !flushW && !stallW;

    // Pipeline register. A flush only needs to kill the control bits; the
    // data fields are don't-care for a bubble, so they are loaded anyway to
    // keep the data enable simple. A stall freezes everything.
    always_ff @(posedge clk) begin
        if (!rst) begin
            validW       <= 1'b0;
            reg_write_w  <= 1'b0;
            result_src_w <= 2'b00;
            funct3_w     <= 3'b000;
            alu_result_w <= '0;
            read_data_w  <= '0;
            pc_plus4_w   <= '0;
            imm_ext_w    <= '0;
            RdW          <= '0;
        end else if (flushW) begin
            validW       <= 1'b0;
            reg_write_w  <= 1'b0;
            result_src_w <= ResultSrcM;
            funct3_w     <= funct3M;
            alu_result_w <= ALUresultM;
            read_data_w  <= ReadDataM;
            pc_plus4_w   <= PCplus4M;
            imm_ext_w    <= ImmExtM;
            RdW          <= RdM;
        end else if (!stallW) begin
            validW       <= validM;
            reg_write_w  <= RegWriteM;
            result_src_w <= ResultSrcM;
            funct3_w     <= funct3M;
            alu_result_w <= ALUresultM;
            read_data_w  <= ReadDataM;
            pc_plus4_w   <= PCplus4M;
            imm_ext_w    <= ImmExtM;
            RdW          <= RdM;
        end
    end

    // Retire counter: an instruction is counted exactly once, on the edge it
    // enters WB. Stalled edges do not load, so a held instruction is never
    // counted twice; bubbles and flushed slots are not counted at all.
    always_ff @(posedge clk) begin
        if (!rst) begin
            retire_count <= '0;
        end else if (load_en && validM) begin
            retire_count <= retire_count + 1'b1;
        end
    end

    // Byte and halfword extraction from the lower word of the memory data.
    // The halfword lane ignores address bit 0 (misaligned halves are not
    // supported; the aligned half containing the address is returned).
    always_comb begin
        offset_w  = alu_result_w[1:0];
        load_byte = read_data_w[7:0];
        case (offset_w)
            2'd0:    load_byte = read_data_w[7:0];
            2'd1:    load_byte = read_data_w[15:8];
            2'd2:    load_byte = read_data_w[23:16];
            default: load_byte = read_data_w[31:24];
        endcase
        load_half = offset_w[1] ? read_data_w[31:16] : read_data_w[15:0];
    end

    // Sign/zero extension by funct3; unlisted encodings pass the whole word.
    always_comb begin
        case (funct3_w)
            3'b000:  load_ext = {{(XLEN-8){load_byte[7]}}, load_byte};
            3'b100:  load_ext = {{(XLEN-8){1'b0}}, load_byte};
            3'b001:  load_ext = {{(XLEN-16){load_half[15]}}, load_half};
            3'b101:  load_ext = {{(XLEN-16){1'b0}}, load_half};
            default: load_ext = read_data_w;
        endcase
    end

    // Result select, combinational from the registered fields.
    always_comb begin
        case (result_src_w)
            2'b00:   ResultW = alu_result_w;
            2'b01:   ResultW = load_ext;
            2'b10:   ResultW = pc_plus4_w;
            default: ResultW = imm_ext_w;
        endcase
    end

    // x0 is hardwired to zero, so a write to it is never presented.
    assign RegWriteW = reg_write_w && validW && (RdW != '0);

endmodule

// File: tb/tb_writeback_stage_reg.sv
// tb_writeback_stage_reg
//
// Directed bench for writeback_stage_reg. Two instances share the stimulus:
// dut uses the default 32-bit retire counter, dut4 uses a 4-bit counter so
// that wrap-around can be observed. Expected values are hand-computed.

module tb_writeback_stage_reg;

    logic        clk;
    logic        rst;
    logic        stallW;
    logic        flushW;
    logic        validM;
    logic        RegWriteM;
    logic [1:0]  ResultSrcM;
    logic [2:0]  funct3M;
    logic [31:0] ALUresultM;
    logic [31:0] ReadDataM;
    logic [31:0] PCplus4M;
    logic [31:0] ImmExtM;
    logic [4:0]  RdM;

    logic [31:0] ResultW;
    logic [4:0]  RdW;
    logic        RegWriteW;
    logic        validW;
    logic [31:0] retire_count;

    logic [31:0] ResultW4;
    logic [4:0]  RdW4;
    logic        RegWriteW4;
    logic        validW4;
    logic [3:0]  retire_count4;

    int compared;
    int mismatched;

    writeback_stage_reg #(.XLEN(32), .RADDR(5), .CNTW(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .stallW       (stallW),
        .flushW       (flushW),
        .validM       (validM),
        .RegWriteM    (RegWriteM),
        .ResultSrcM   (ResultSrcM),
        .funct3M      (funct3M),
        .ALUresultM   (ALUresultM),
        .ReadDataM    (ReadDataM),
        .PCplus4M     (PCplus4M),
        .ImmExtM      (ImmExtM),
        .RdM          (RdM),
        .ResultW      (ResultW),
        .RdW          (RdW),
        .RegWriteW    (RegWriteW),
        .validW       (validW),
        .retire_count (retire_count)
    );

    writeback_stage_reg #(.XLEN(32), .RADDR(5), .CNTW(4)) dut4 (
        .clk          (clk),
        .rst          (rst),
        .stallW       (stallW),
        .flushW       (flushW),
        .validM       (validM),
        .RegWriteM    (RegWriteM),
        .ResultSrcM   (ResultSrcM),
        .funct3M      (funct3M),
        .ALUresultM   (ALUresultM),
        .ReadDataM    (ReadDataM),
        .PCplus4M     (PCplus4M),
        .ImmExtM      (ImmExtM),
        .RdM          (RdM),
        .ResultW      (ResultW4),
        .RdW          (RdW4),
        .RegWriteW    (RegWriteW4),
        .validW       (validW4),
        .retire_count (retire_count4)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one set of M-stage inputs, let one rising edge pass, then settle
    // 1 ns past the edge so outputs are sampled away from it.
    task automatic applyStimulus(
        input logic        r,
        input logic        st,
        input logic        fl,
        input logic        v,
        input logic        rw,
        input logic [1:0]  src,
        input logic [2:0]  f3,
        input logic [31:0] alu,
        input logic [31:0] rdata,
        input logic [31:0] pc4,
        input logic [31:0] imm,
        input logic [4:0]  rd
    );
        rst        = r;
        stallW     = st;
        flushW     = fl;
        validM     = v;
        RegWriteM  = rw;
        ResultSrcM = src;
        funct3M    = f3;
        ALUresultM = alu;
        ReadDataM  = rdata;
        PCplus4M   = pc4;
        ImmExtM    = imm;
        RdM        = rd;
        @(posedge clk);
        #1;
    endtask

    // One comparison of an observed value against its hand-computed value.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    localparam logic [31:0] LDATA = 32'h80F0_7F81;

    initial begin
        compared   = 0;
        mismatched = 0;

        // Reset for two cycles with random M inputs.
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                          2'($urandom), 3'($urandom), $urandom, $urandom, $urandom,
                          $urandom, 5'($urandom));
        end
        $display("[TB] reset checks");
        checkOutput("rst_ResultW",   64'(ResultW),       64'h0);
        checkOutput("rst_RdW",       64'(RdW),           64'h0);
        checkOutput("rst_RegWriteW", 64'(RegWriteW),     64'h0);
        checkOutput("rst_validW",    64'(validW),        64'h0);
        checkOutput("rst_count",     64'(retire_count),  64'h0);
        checkOutput("rst_count4",    64'(retire_count4), 64'h0);

        // First instruction after reset release: ALU result to x5.
        applyStimulus(1, 0, 0, 1, 1, 2'b00, 3'b000, 32'h1234, 0, 0, 0, 5'd5);
        checkOutput("first_ResultW",   64'(ResultW),      64'h1234);
        checkOutput("first_RdW",       64'(RdW),          64'd5);
        checkOutput("first_RegWriteW", 64'(RegWriteW),    64'h1);
        checkOutput("first_validW",    64'(validW),       64'h1);
        checkOutput("first_count",     64'(retire_count), 64'd1);

        // Load extension sweep on 0x80F07F81.
        $display("[TB] load extension checks");
        applyStimulus(1, 0, 0, 1, 1, 2'b01, 3'b000, 32'h1000, LDATA, 0, 0, 5'd6);
        checkOutput("lb_off0", 64'(ResultW), 64'hFFFF_FF81);
        applyStimulus(1, 0, 0, 1, 1, 2'b01, 3'b100, 32'h1003, LDATA, 0, 0, 5'd6);
        checkOutput("lbu_off3", 64'(ResultW), 64'h0000_0080);
        applyStimulus(1, 0, 0, 1, 1, 2'b01, 3'b001, 32'h1002, LDATA, 0, 0, 5'd6);
        checkOutput("lh_off2", 64'(ResultW), 64'hFFFF_80F0);
        applyStimulus(1, 0, 0, 1, 1, 2'b01, 3'b101, 32'h1000, LDATA, 0, 0, 5'd6);
        checkOutput("lhu_off0", 64'(ResultW), 64'h0000_7F81);
        applyStimulus(1, 0, 0, 1, 1, 2'b01, 3'b010, 32'h1000, LDATA, 0, 0, 5'd6);
        checkOutput("lw", 64'(ResultW), 64'h80F0_7F81);
        applyStimulus(1, 0, 0, 1, 1, 2'b01, 3'b000, 32'h1001, LDATA, 0, 0, 5'd6);
        checkOutput("lb_off1", 64'(ResultW), 64'h0000_007F);
        applyStimulus(1, 0, 0, 1, 1, 2'b01, 3'b100, 32'h1002, LDATA, 0, 0, 5'd6);
        checkOutput("lbu_off2", 64'(ResultW), 64'h0000_00F0);
        applyStimulus(1, 0, 0, 1, 1, 2'b01, 3'b001, 32'h1003, LDATA, 0, 0, 5'd6);
        checkOutput("lh_off3", 64'(ResultW), 64'hFFFF_80F0);
        applyStimulus(1, 0, 0, 1, 1, 2'b01, 3'b011, 32'h1001, LDATA, 0, 0, 5'd6);
        checkOutput("f3_011_word", 64'(ResultW), 64'h80F0_7F81);
        checkOutput("load_count",  64'(retire_count), 64'd10);

        // Other result sources and x0 suppression.
        $display("[TB] source and x0 checks");
        applyStimulus(1, 0, 0, 1, 1, 2'b10, 3'b000, 32'h55, 0, 32'h104, 32'h77, 5'd1);
        checkOutput("src_pc4", 64'(ResultW), 64'h104);
        applyStimulus(1, 0, 0, 1, 1, 2'b11, 3'b000, 32'h55, 0, 32'h104, 32'hABCD_E000, 5'd2);
        checkOutput("src_imm", 64'(ResultW), 64'hABCD_E000);
        applyStimulus(1, 0, 0, 1, 1, 2'b00, 3'b000, 32'h55, 0, 0, 0, 5'd0);
        checkOutput("x0_RegWriteW", 64'(RegWriteW), 64'h0);
        checkOutput("x0_validW",    64'(validW),    64'h1);
        applyStimulus(1, 0, 0, 1, 0, 2'b00, 3'b000, 32'h66, 0, 0, 0, 5'd7);
        checkOutput("norw_RegWriteW", 64'(RegWriteW), 64'h0);
        checkOutput("norw_count",     64'(retire_count), 64'd14);

        // Bubble entering from M.
        applyStimulus(1, 0, 0, 0, 1, 2'b00, 3'b000, 32'h99, 0, 0, 0, 5'd8);
        checkOutput("bubble_validW",    64'(validW),       64'h0);
        checkOutput("bubble_RegWriteW", 64'(RegWriteW),    64'h0);
        checkOutput("bubble_count",     64'(retire_count), 64'd14);

        // Instruction A, then three stall cycles while M keeps changing.
        $display("[TB] stall and flush checks");
        applyStimulus(1, 0, 0, 1, 1, 2'b00, 3'b000, 32'hAAAA, 0, 0, 0, 5'd9);
        checkOutput("A_ResultW", 64'(ResultW),      64'hAAAA);
        checkOutput("A_count",   64'(retire_count), 64'd15);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 1, 0, 1, 1, 2'b10, 3'b000, 32'hBBB0 + i, 0, 32'h200 + i, 0,
                          5'(10 + i));
            checkOutput("stall_ResultW",   64'(ResultW),      64'hAAAA);
            checkOutput("stall_RdW",       64'(RdW),          64'd9);
            checkOutput("stall_RegWriteW", 64'(RegWriteW),    64'h1);
            checkOutput("stall_count",     64'(retire_count), 64'd15);
        end

        // Stall and flush together: flush wins.
        applyStimulus(1, 1, 1, 1, 1, 2'b00, 3'b000, 32'hCCCC, 0, 0, 0, 5'd11);
        checkOutput("stflush_validW",    64'(validW),       64'h0);
        checkOutput("stflush_RegWriteW", 64'(RegWriteW),    64'h0);
        checkOutput("stflush_count",     64'(retire_count), 64'd15);

        // Normal load after the flush, then a plain flush.
        applyStimulus(1, 0, 0, 1, 1, 2'b00, 3'b000, 32'hDDDD, 0, 0, 0, 5'd12);
        checkOutput("postflush_ResultW", 64'(ResultW),      64'hDDDD);
        checkOutput("postflush_count",   64'(retire_count), 64'd16);
        checkOutput("postflush_count4",  64'(retire_count4), 64'd0);
        applyStimulus(1, 0, 1, 1, 1, 2'b00, 3'b000, 32'hEEEE, 0, 0, 0, 5'd13);
        checkOutput("flush_validW", 64'(validW),       64'h0);
        checkOutput("flush_count",  64'(retire_count), 64'd16);

        // Reset asserted during a stall clears everything.
        applyStimulus(1, 0, 0, 1, 1, 2'b00, 3'b000, 32'hF00D, 0, 0, 0, 5'd14);
        applyStimulus(1, 1, 0, 1, 1, 2'b00, 3'b000, 32'h1111, 0, 0, 0, 5'd15);
        checkOutput("prerst_ResultW", 64'(ResultW), 64'hF00D);
        applyStimulus(0, 1, 0, 1, 1, 2'b00, 3'b000, 32'h1111, 0, 0, 0, 5'd15);
        checkOutput("midrst_ResultW", 64'(ResultW),      64'h0);
        checkOutput("midrst_RdW",     64'(RdW),          64'h0);
        checkOutput("midrst_validW",  64'(validW),       64'h0);
        checkOutput("midrst_count",   64'(retire_count), 64'h0);

        // Counter wrap: 17 valid instructions with bubbles interleaved.
        $display("[TB] counter wrap checks");
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1, 0, 0, 1, 1, 2'b00, 3'b000, 32'(i), 0, 0, 0, 5'd3);
            if (i % 5 == 2) begin
                applyStimulus(1, 0, 0, 0, 0, 2'b00, 3'b000, 32'h0, 0, 0, 0, 5'd0);
            end
        end
        checkOutput("wrap16_count4", 64'(retire_count4), 64'd0);
        checkOutput("wrap16_count",  64'(retire_count),  64'd16);
        applyStimulus(1, 0, 0, 0, 1, 2'b00, 3'b000, 32'h0, 0, 0, 0, 5'd3);
        checkOutput("wrapbub_count4", 64'(retire_count4), 64'd0);
        applyStimulus(1, 0, 0, 1, 1, 2'b00, 3'b000, 32'h42, 0, 0, 0, 5'd3);
        checkOutput("wrap17_count4", 64'(retire_count4), 64'd1);
        checkOutput("wrap17_count",  64'(retire_count),  64'd17);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/writeback_stage_reg.md
Name: writeback_stage_reg

Overview:
- Parametrised successor to the plain writeback mux: it owns the MEM/WB pipeline register and the rest of the writeback path.
- Adds stall/flush control, a valid bit, four-way result selection, load data alignment with sign/zero extension, x0 write suppression, and a retired-instruction counter.
- Sits between the memory stage and the register file / forwarding unit of the 5-stage RISC-V pipeline.

Parameters:
- XLEN, 32, datapath width (32 or 64; loads above word are not in scope)
- RADDR, 5, register-address width
- CNTW, 32, retire counter width

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  reset, synchronous, active-low
- stallW  input  1  hold WB register contents
- flushW  input  1  replace incoming instruction with a bubble
- validM  input  1  memory-stage instruction valid
- RegWriteM  input  1  instruction writes rd
- ResultSrcM  input  2  00 ALU, 01 load, 10 PC+4, 11 immediate
- funct3M  input  3  load size/sign encoding
- ALUresultM  input  XLEN  ALU result / load address
- ReadDataM  input  XLEN  raw aligned memory word
- PCplus4M  input  XLEN  link value
- ImmExtM  input  XLEN  extended immediate (LUI)
- RdM  input  RADDR  destination register
- ResultW  output  XLEN  value written to the register file
- RdW  output  RADDR  destination register
- RegWriteW  output  1  effective register-file write enable
- validW  output  1  WB stage holds a real instruction
- retire_count  output  CNTW  count of retired instructions

Behaviour:
- Reset: on a clk edge with rst=0, all pipeline registers clear. validW=0, RegWriteW=0, RdW=0, ResultW=0, retire_count=0. Reset overrides stall and flush.
- Register update priority per edge: reset > flushW > stallW > load.
  - flushW=1: validW and RegWrite are cleared. Data fields may load but are don't-care.
  - stallW=1 (no flush): every field holds its value.
  - Otherwise: all M-stage fields are captured.
- Latency: one cycle from M inputs to W outputs. ResultW is combinational from the registered fields; there is no extra cycle.
- Load extension (ResultSrc=01), using offset = ALUresultW[1:0]:
  - Byte = ReadData[8*offset+7 : 8*offset].
  - Half = ReadData[31:16] if offset[1], else [15:0]; offset[0] is ignored.
  - funct3 000 LB sign-extends byte; 100 LBU zero-extends byte.
  - funct3 001 LH sign-extends half; 101 LHU zero-extends half.
  - funct3 010 LW passes the word. All other codes also pass the word.
- Result mux: 00 ALUresultW, 01 extended load, 10 PCplus4W, 11 ImmExtW.
- RegWriteW = registered RegWrite AND validW AND (RdW != 0). Writes to x0 are never asserted.
- retire_count increments by 1 on each edge where the WB register loads (rst=1, no flush, no stall) with validM=1.
  - It wraps modulo 2^CNTW; no saturation.
  - No increment on stall cycles, so a stalled instruction is never double-counted.
  - A bubble (validM=0) does not count.
- Simultaneous stall and flush: flush wins; a bubble enters and the count does not change.
- Reset asserted mid-stall: the next edge clears everything; pipeline contents are lost by design.

Test Plan:
- Reset: hold rst=0 for 2 cycles with random inputs → every output 0. Release with validM=1, RegWriteM=1, RdM=5, ResultSrcM=00, ALUresultM=0x1234 → next cycle ResultW=0x1234, RegWriteW=1, retire_count=1.
- Load extension: ReadDataM=0x80F0_7F81, sweeping offsets:
  - LB offset 0 → 0xFFFFFF81
  - LBU offset 3 → 0x00000080
  - LH offset 2 → 0xFFFF80F0
  - LHU offset 0 → 0x00007F81
  - LW → 0x80F07F81
- Sources: ResultSrc 10 with PCplus4M=0x104 → ResultW=0x104. ResultSrc 11 with ImmExtM=0xABCDE000 → 0xABCDE000. RdM=0 with RegWriteM=1 → RegWriteW=0.
- Stall/flush: load instruction A, then assert stallW 3 cycles while M changes → W outputs hold A and retire_count rises by 1 total. Assert stallW and flushW together → validW=0, RegWriteW=0, count unchanged.
- Counter wrap: CNTW=4, 17 consecutive valid instructions → retire_count=1. Interleaved validM=0 bubbles are not counted.
